dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//   Shares the single-port, 1-cycle-read-latency data memory SRAM between two requesters:
//   port 0 is the core's load/store path and port 1 is the host loader/debug access path.
//   Each cycle the block grants at most one request and drives the SRAM address, data and
//   write-enable. It routes read data back with a per-port valid strobe.
//   A starvation guard ensures port 1 makes progress under fixed-priority mode.
// PARAMETERS
//   AW            8    SRAM word-address width
//   DW            32   SRAM data width
//   RR_MODE       0    0 = fixed priority (port 0 wins) with starvation guard; 1 = round robin
//   STARVE_LIMIT  4    fixed mode: consecutive denied cycles of port 1 before a forced grant (>=1)
//   CNT_W         16   width of the conflict counter
// PORTS
//   clk          in   1      clock
//   rst          in   1      synchronous reset, active-high
//   p0_req       in   1      port 0 access request; held with addr/we/wdata until p0_gnt
//   p0_we        in   1      port 0 write (1) / read (0)
//   p0_addr      in   AW     port 0 word address
//   p0_wdata     in   DW     port 0 write data
//   p0_gnt       out  1      port 0 access issued this cycle (combinational)
//   p0_rvalid    out  1      port 0 read data valid on rdata (registered)
//   p1_req/p1_we/p1_addr/p1_wdata/p1_gnt/p1_rvalid   same as port 0, for port 1
//   rdata        out  DW     read data, shared by both ports (= mem_dout)
//   mem_addr     out  AW     SRAM address
//   mem_din      out  DW     SRAM write data
//   mem_wea      out  1      SRAM write enable
//   mem_dout     in   DW     SRAM read data, valid the cycle after the address is sampled
//   conflict_cnt out  CNT_W  number of cycles in which both ports requested; saturating
// BEHAVIOUR
//   Grant logic
//   - Combinational from req and state; at most one of p0_gnt/p1_gnt is high per cycle.
//   - A grant for a port whose req is low is illegal.
//   - Only one port requesting: that port is granted.
//   - Both ports requesting, fixed mode: port 0 is granted unless starve_cnt == STARVE_LIMIT,
//     in which case port 1 is granted.
//   - Both ports requesting, RR mode: the port not granted most recently wins.
//     last_gnt updates on every grant; after reset last_gnt = 1, so port 0 wins the first tie.
//   SRAM drive
//   - In the grant cycle, mem_addr, mem_din and mem_wea come from the granted port,
//     with mem_wea = gnt & we.
//   - With no grant: mem_addr = 0, mem_din = 0, mem_wea = 0.
//   Read return
//   - pX_rvalid is registered: pX_rvalid <= pX_gnt & ~pX_we.
//   - rdata = mem_dout. Read latency is 1 cycle from grant.
//   - Writes complete at the grant edge and produce no rvalid.
//   - Back-to-back grants are allowed every cycle, and a read on one port may directly
//     follow a read on the other.
//   Starvation counter (fixed mode only)
//   - starve_cnt increments when p1_req=1 and p1_gnt=0, saturating at STARVE_LIMIT.
//   - It clears when p1_gnt=1 or p1_req=0.
//   - In RR mode starve_cnt is held at 0.
//   conflict_cnt
//   - Increments when p0_req & p1_req, saturating at all-ones. It clears only on rst.
//   Handshake
//   - A requester keeps req/addr/we/wdata stable until its gnt.
//   - It may drop req or change the access in the cycle after gnt.
//   - It may re-request immediately in that same cycle.
//   Reset
//   - While rst=1: both gnt outputs 0, mem_wea 0, mem_addr 0, mem_din 0.
//   - Registered state on the next edge: both rvalid 0, starve_cnt 0, last_gnt 1,
//     conflict_cnt 0.
//   - A read granted the cycle before rst asserts still returns rvalid in the first
//     reset cycle; requesters ignore rvalid during reset.
//   - A read granted in a cycle where rst=1 cannot occur, since grants are suppressed.
// TESTING
//   1. Single port: p0 write 0xDEADBEEF @0x10, then p0 read @0x10
//      -> p0_gnt same cycle each time; p0_rvalid 1 cycle after the read grant with rdata=0xDEADBEEF;
//         p1_rvalid stays 0.
//   2. Fixed mode, STARVE_LIMIT=4, both ports requesting continuously
//      -> p0 granted 4 cycles, p1 granted on the 5th, pattern repeats;
//         conflict_cnt increments every cycle.
//   3. RR mode, both ports requesting continuously from reset
//      -> grants alternate p0,p1,p0,p1...; each read's rvalid lands on the correct port
//         with that port's data.
//   4. Simultaneous p0 write @0x20=0x1 and p1 read @0x20 (RR)
//      -> p0 granted first, p1 next cycle; p1 rvalid with rdata=0x1.
//   5. Reset mid-burst: assert rst while both ports are requesting
//      -> gnt/mem_wea = 0 during rst; after release, conflict_cnt=0, starve_cnt=0,
//         port 0 wins the first tie.
//   6. conflict_cnt saturation with CNT_W=4: 20 conflict cycles -> conflict_cnt holds at 15.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of a single-port, 1-cycle-read-latency data SRAM.
// Port 0 is the core load/store path and port 1 is the host loader/debug path.
// Grants are combinational, so an access reaches the SRAM in its request cycle.
// Read data comes back on the shared rdata bus with a registered per-port
// valid strobe.
module dmem_port_arbiter #(
  parameter int AW           = 8,
  parameter int DW           = 32,
  parameter int RR_MODE      = 0,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p0_req,
  input  logic             p0_we,
  input  logic [AW-1:0]    p0_addr,
  input  logic [DW-1:0]    p0_wdata,
  output logic             p0_gnt,
  output logic             p0_rvalid,
  input  logic             p1_req,
  input  logic             p1_we,
  input  logic [AW-1:0]    p1_addr,
  input  logic [DW-1:0]    p1_wdata,
  output logic             p1_gnt,
  output logic             p1_rvalid,
  output logic [DW-1:0]    rdata,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_din,
  output logic             mem_wea,
  input  logic [DW-1:0]    mem_dout,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0]    starve_q, starve_d;
  logic             last_gnt_q, last_gnt_d;
  logic             p0_rvalid_q, p1_rvalid_q;
  logic [CNT_W-1:0] conflict_q, conflict_d;
  logic             both_req;
  logic             pick1;

  // Grant selection: a lone requester always wins; a tie goes to port 0
  // unless the starvation guard (fixed) or alternation (round robin) says
  // otherwise. Nothing is granted while in reset.
  always_comb begin
    both_req = p0_req & p1_req;
    if (RR_MODE != 0) pick1 = ~last_gnt_q;
    else              pick1 = (starve_q == SW'(STARVE_LIMIT));
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!rst) begin
      if (both_req) begin
        p1_gnt = pick1;
        p0_gnt = ~pick1;
      end else begin
        p0_gnt = p0_req;
        p1_gnt = p1_req;
      end
    end
  end

  // SRAM drive: mux the granted port onto the memory, idle to all zeros.
  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_wea  = 1'b0;
    if (p0_gnt) begin
      mem_addr = p0_addr;
      mem_din  = p0_wdata;
      mem_wea  = p0_we;
    end else if (p1_gnt) begin
      mem_addr = p1_addr;
      mem_din  = p1_wdata;
      mem_wea  = p1_we;
    end
  end

  // Next-state for the starvation guard, the round-robin pointer and the
  // saturating conflict counter.
  always_comb begin
    starve_d = '0;
    if (RR_MODE == 0 && p1_req && !p1_gnt) begin
      if (starve_q == SW'(STARVE_LIMIT)) starve_d = starve_q;
      else                               starve_d = starve_q + SW'(1);
    end
    last_gnt_d = last_gnt_q;
    if (p0_gnt)      last_gnt_d = 1'b0;
    else if (p1_gnt) last_gnt_d = 1'b1;
    conflict_d = conflict_q;
    if (both_req && conflict_q != {CNT_W{1'b1}}) conflict_d = conflict_q + CNT_W'(1);
  end

  // State registers; read-valid strobes trail their read grant by one cycle
  // to line up with the SRAM output.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q    <= '0;
      last_gnt_q  <= 1'b1;
      conflict_q  <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      last_gnt_q  <= last_gnt_d;
      conflict_q  <= conflict_d;
      p0_rvalid_q <= p0_gnt & ~p0_we;
      p1_rvalid_q <= p1_gnt & ~p1_we;
    end
  end

  assign p0_rvalid    = p0_rvalid_q;
  assign p1_rvalid    = p1_rvalid_q;
  assign rdata        = mem_dout;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: a fixed-priority instance (STARVE_LIMIT=4,
// 4-bit conflict counter) and a round-robin instance share one stimulus,
// each with its own SRAM model.
module tb_dmem_port_arbiter;

  logic        clk, rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [7:0]  p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;

  logic        f_p0_gnt, f_p1_gnt, f_p0_rv, f_p1_rv, f_wea;
  logic [31:0] f_rdata, f_din, f_dout;
  logic [7:0]  f_addr;
  logic [3:0]  f_cnt;
  logic        r_p0_gnt, r_p1_gnt, r_p0_rv, r_p1_rv, r_wea;
  logic [31:0] r_rdata, r_din, r_dout;
  logic [7:0]  r_addr;
  logic [15:0] r_cnt;

  logic [31:0] mem_f [256];
  logic [31:0] mem_r [256];

  int n_pass = 0;
  int n_tot  = 0;

  dmem_port_arbiter #(.AW(8), .DW(32), .RR_MODE(0), .STARVE_LIMIT(4), .CNT_W(4)) u_f (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(f_p0_gnt), .p0_rvalid(f_p0_rv),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(f_p1_gnt), .p1_rvalid(f_p1_rv),
    .rdata(f_rdata), .mem_addr(f_addr), .mem_din(f_din), .mem_wea(f_wea),
    .mem_dout(f_dout), .conflict_cnt(f_cnt));

  dmem_port_arbiter #(.AW(8), .DW(32), .RR_MODE(1), .STARVE_LIMIT(4), .CNT_W(16)) u_r (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(r_p0_gnt), .p0_rvalid(r_p0_rv),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(r_p1_gnt), .p1_rvalid(r_p1_rv),
    .rdata(r_rdata), .mem_addr(r_addr), .mem_din(r_din), .mem_wea(r_wea),
    .mem_dout(r_dout), .conflict_cnt(r_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SRAM models, 1-cycle read latency.
  always @(posedge clk) begin
    if (f_wea) mem_f[f_addr] <= f_din;
    f_dout <= mem_f[f_addr];
    if (r_wea) mem_r[r_addr] <= r_din;
    r_dout <= mem_r[r_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic a_req, input logic a_we, input logic [7:0] a_addr,
                       input logic [31:0] a_d, input logic b_req, input logic b_we,
                       input logic [7:0] b_addr, input logic [31:0] b_d);
    p0_req = a_req; p0_we = a_we; p0_addr = a_addr; p0_wdata = a_d;
    p1_req = b_req; p1_we = b_we; p1_addr = b_addr; p1_wdata = b_d;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        p0r, p0w; logic [7:0] p0a; logic [31:0] p0d;
    logic        p1r, p1w; logic [7:0] p1a; logic [31:0] p1d;
    logic [1:0]  gf, gr, vf, vr;
    logic [31:0] df, dr;
    logic        wea; logic [7:0] ma;
    logic [3:0]  cf; logic [15:0] cr;
  } vec_t;

  localparam logic [31:0] D = 32'hDEADBEEF;
  localparam logic [31:0] C = 32'hCAFE0001;

  vec_t vt [15];

  initial begin
    // Single-port write/read, then p1 write, then both ports reading continuously.
    vt[0]  = '{1'b1,1'b1,8'h10,D,     1'b0,1'b0,8'h00,32'h0, 2'b01,2'b01,2'b00,2'b00,32'h0,32'h0,1'b1,8'h10,4'd0,16'd0};
    vt[1]  = '{1'b1,1'b0,8'h10,32'h0, 1'b0,1'b0,8'h00,32'h0, 2'b01,2'b01,2'b00,2'b00,32'h0,32'h0,1'b0,8'h10,4'd0,16'd0};
    vt[2]  = '{1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,8'h00,32'h0, 2'b00,2'b00,2'b01,2'b01,D,D,       1'b0,8'h00,4'd0,16'd0};
    vt[3]  = '{1'b0,1'b0,8'h00,32'h0, 1'b1,1'b1,8'h11,C,     2'b10,2'b10,2'b00,2'b00,32'h0,32'h0,1'b1,8'h11,4'd0,16'd0};
    vt[4]  = '{1'b1,1'b0,8'h10,32'h0, 1'b1,1'b0,8'h11,32'h0, 2'b01,2'b01,2'b00,2'b00,32'h0,32'h0,1'b0,8'h10,4'd0,16'd0};
    vt[5]  = '{1'b1,1'b0,8'h10,32'h0, 1'b1,1'b0,8'h11,32'h0, 2'b01,2'b10,2'b01,2'b01,D,D,       1'b0,8'h10,4'd1,16'd1};
    vt[6]  = '{1'b1,1'b0,8'h10,32'h0, 1'b1,1'b0,8'h11,32'h0, 2'b01,2'b01,2'b01,2'b10,D,C,       1'b0,8'h10,4'd2,16'd2};
    vt[7]  = '{1'b1,1'b0,8'h10,32'h0, 1'b1,1'b0,8'h11,32'h0, 2'b01,2'b10,2'b01,2'b01,D,D,       1'b0,8'h10,4'd3,16'd3};
    vt[8]  = '{1'b1,1'b0,8'h10,32'h0, 1'b1,1'b0,8'h11,32'h0, 2'b10,2'b01,2'b01,2'b10,D,C,       1'b0,8'h11,4'd4,16'd4};
    vt[9]  = '{1'b1,1'b0,8'h10,32'h0, 1'b1,1'b0,8'h11,32'h0, 2'b01,2'b10,2'b10,2'b01,C,D,       1'b0,8'h10,4'd5,16'd5};
    vt[10] = '{1'b1,1'b0,8'h10,32'h0, 1'b1,1'b0,8'h11,32'h0, 2'b01,2'b01,2'b01,2'b10,D,C,       1'b0,8'h10,4'd6,16'd6};
    vt[11] = '{1'b1,1'b0,8'h10,32'h0, 1'b1,1'b0,8'h11,32'h0, 2'b01,2'b10,2'b01,2'b01,D,D,       1'b0,8'h10,4'd7,16'd7};
    vt[12] = '{1'b1,1'b0,8'h10,32'h0, 1'b1,1'b0,8'h11,32'h0, 2'b01,2'b01,2'b01,2'b10,D,C,       1'b0,8'h10,4'd8,16'd8};
    vt[13] = '{1'b1,1'b0,8'h10,32'h0, 1'b1,1'b0,8'h11,32'h0, 2'b10,2'b10,2'b01,2'b01,D,D,       1'b0,8'h11,4'd9,16'd9};
    vt[14] = '{1'b0,1'b0,8'h00,32'h0, 1'b0,1'b0,8'h00,32'h0, 2'b00,2'b00,2'b10,2'b10,C,C,       1'b0,8'h00,4'd10,16'd10};

    // Reset with both ports requesting writes: nothing may reach the SRAM.
    rst = 1'b1;
    drive(1'b1, 1'b1, 8'h33, 32'h12345678, 1'b1, 1'b1, 8'h44, 32'h9ABCDEF0);
    @(negedge clk);
    chk("rst f_gnt", 32'({f_p1_gnt, f_p0_gnt}), 32'd0);
    chk("rst r_gnt", 32'({r_p1_gnt, r_p0_gnt}), 32'd0);
    chk("rst f_wea", 32'(f_wea), 32'd0);
    chk("rst f_addr", 32'(f_addr), 32'd0);
    chk("rst f_din", f_din, 32'd0);
    next_cyc();
    @(negedge clk);
    chk("rst f_rvalid", 32'({f_p1_rv, f_p0_rv}), 32'd0);
    chk("rst r_rvalid", 32'({r_p1_rv, r_p0_rv}), 32'd0);
    chk("rst f_cnt", 32'(f_cnt), 32'd0);
    chk("rst r_cnt", 32'(r_cnt), 32'd0);
    next_cyc();
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 15; i++) begin
      drive(vt[i].p0r, vt[i].p0w, vt[i].p0a, vt[i].p0d, vt[i].p1r, vt[i].p1w, vt[i].p1a, vt[i].p1d);
      @(negedge clk);
      chk($sformatf("v%0d f_gnt", i), 32'({f_p1_gnt, f_p0_gnt}), 32'(vt[i].gf));
      chk($sformatf("v%0d r_gnt", i), 32'({r_p1_gnt, r_p0_gnt}), 32'(vt[i].gr));
      chk($sformatf("v%0d f_rvalid", i), 32'({f_p1_rv, f_p0_rv}), 32'(vt[i].vf));
      chk($sformatf("v%0d r_rvalid", i), 32'({r_p1_rv, r_p0_rv}), 32'(vt[i].vr));
      if (vt[i].vf != 2'b00) chk($sformatf("v%0d f_rdata", i), f_rdata, vt[i].df);
      if (vt[i].vr != 2'b00) chk($sformatf("v%0d r_rdata", i), r_rdata, vt[i].dr);
      chk($sformatf("v%0d f_wea", i), 32'(f_wea), 32'(vt[i].wea));
      chk($sformatf("v%0d f_addr", i), 32'(f_addr), 32'(vt[i].ma));
      chk($sformatf("v%0d f_cnt", i), 32'(f_cnt), 32'(vt[i].cf));
      chk($sformatf("v%0d r_cnt", i), 32'(r_cnt), 32'(vt[i].cr));
      next_cyc();
    end

    // RR: p0 write @0x20 and p1 read @0x20 together; p1 must see the new data.
    drive(1'b1, 1'b1, 8'h20, 32'h1, 1'b1, 1'b0, 8'h20, 32'h0);
    @(negedge clk);
    chk("wr_rd r_gnt A", 32'({r_p1_gnt, r_p0_gnt}), 32'b01);
    chk("wr_rd r_wea A", 32'(r_wea), 32'd1);
    chk("wr_rd r_din A", r_din, 32'h1);
    next_cyc();
    drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0);
    @(negedge clk);
    chk("wr_rd r_gnt B", 32'({r_p1_gnt, r_p0_gnt}), 32'b10);
    chk("wr_rd r_addr B", 32'(r_addr), 32'h20);
    chk("wr_rd r_wea B", 32'(r_wea), 32'd0);
    next_cyc();
    drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk);
    chk("wr_rd r_rvalid", 32'({r_p1_rv, r_p0_rv}), 32'b10);
    chk("wr_rd r_rdata", r_rdata, 32'h1);
    next_cyc();

    // Reset mid-burst: one tie (rr grants p0, fixed guard starts counting),
    // then reset with requests still held.
    drive(1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 8'h11, 32'h0);
    @(negedge clk);
    chk("burst r_gnt", 32'({r_p1_gnt, r_p0_gnt}), 32'b01);
    next_cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst f_gnt", 32'({f_p1_gnt, f_p0_gnt}), 32'd0);
    chk("midrst r_gnt", 32'({r_p1_gnt, r_p0_gnt}), 32'd0);
    chk("midrst r_wea", 32'(r_wea), 32'd0);
    chk("midrst r_addr", 32'(r_addr), 32'd0);
    chk("midrst r_p0_rvalid", 32'(r_p0_rv), 32'd1);
    chk("midrst r_rdata", r_rdata, D);
    next_cyc();
    @(negedge clk);
    chk("midrst2 r_rvalid", 32'({r_p1_rv, r_p0_rv}), 32'd0);
    chk("midrst2 f_cnt", 32'(f_cnt), 32'd0);
    chk("midrst2 r_cnt", 32'(r_cnt), 32'd0);
    next_cyc();
    rst = 1'b0;

    // Continuous ties after reset: fixed pattern p0 x4 then p1, rr alternates
    // starting at p0, and the 4-bit conflict counter saturates at 15.
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      chk($sformatf("post k%0d f_gnt", k), 32'({f_p1_gnt, f_p0_gnt}),
          (k % 5 == 4) ? 32'b10 : 32'b01);
      chk($sformatf("post k%0d r_gnt", k), 32'({r_p1_gnt, r_p0_gnt}),
          (k % 2 == 1) ? 32'b10 : 32'b01);
      chk($sformatf("post k%0d f_cnt", k), 32'(f_cnt), (k > 15) ? 32'd15 : 32'(k));
      chk($sformatf("post k%0d r_cnt", k), 32'(r_cnt), 32'(k));
      next_cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
